// File: rtl/sn_arbiter.sv
// sn_arbiter: round-robin arbiter that shares the single snooper write port
// among N packetfilter cores. One idle core is offered to the snooper.
// Write strobes and done pulses are steered to that core only. Address and
// data are broadcast elsewhere, so only the enables are handled here.
module sn_arbiter #(
  parameter int N         = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         core_rdy,
  output logic [N-1:0]         core_rdy_ack,
  output logic [N-1:0]         core_wr_en,
  output logic [N-1:0]         core_done,
  output logic                 sn_rdy,
  input  logic                 sn_rdy_ack,
  input  logic                 sn_wr_en,
  input  logic                 sn_done,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic                 busy,
  output logic                 stray_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;
  logic [SEL_WIDTH-1:0] rr_idx;
  logic [SEL_WIDTH-1:0] cand_idx;
  logic                 rr_found;
  logic                 stray_q;
  int unsigned          cand;

  // Round-robin search: first ready core from last+1 upward, wrapping mod N
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand     = (32'(last_q) + i) % N;
      cand_idx = SEL_WIDTH'(cand);
      if (!rr_found && core_rdy[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SEL_WIDTH'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and steered outputs, all decoded from registered state
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    sn_rdy       = 1'b0;
    core_rdy_ack = '0;
    core_wr_en   = '0;
    core_done    = '0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        sn_rdy = core_rdy[grant_q];
        if (!core_rdy[grant_q]) begin
          // Withdrawn offer: pointer untouched so the search restarts in place
          state_d = IDLE;
        end else if (sn_rdy_ack) begin
          core_rdy_ack[grant_q] = 1'b1;
          last_d                = grant_q;
          state_d               = BUSY;
        end
      end
      BUSY: begin
        core_wr_en[grant_q] = sn_wr_en;
        core_done[grant_q]  = sn_done;
        if (sn_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flag for end-of-packet pulses arriving outside a packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stray_q <= 1'b0;
    else if (sn_done && state_q != BUSY) stray_q <= 1'b1;
  end

  assign grant_idx  = grant_q;
  assign busy       = (state_q == BUSY);
  assign stray_done = stray_q;

endmodule

// File: tb/tb_sn_arbiter.sv
// Scoreboard bench for sn_arbiter: stimulus pushes expected steered outputs
// into queues, a negedge monitor pops and compares whenever the DUT drives one.
module tb_sn_arbiter;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  core_rdy;
  logic [N-1:0]  core_rdy_ack;
  logic [N-1:0]  core_wr_en;
  logic [N-1:0]  core_done;
  logic          sn_rdy;
  logic          sn_rdy_ack;
  logic          sn_wr_en;
  logic          sn_done;
  logic [SW-1:0] grant_idx;
  logic          busy;
  logic          stray_done;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] ack_q[$];
  logic [N-1:0] wr_q[$];
  logic [N-1:0] done_q[$];

  sn_arbiter #(.N(N), .SEL_WIDTH(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_rdy     (core_rdy),
    .core_rdy_ack (core_rdy_ack),
    .core_wr_en   (core_wr_en),
    .core_done    (core_done),
    .sn_rdy       (sn_rdy),
    .sn_rdy_ack   (sn_rdy_ack),
    .sn_wr_en     (sn_wr_en),
    .sn_done      (sn_done),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .stray_done   (stray_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every nonzero steered output must match the next queued entry
  always @(negedge clk) begin
    if (core_rdy_ack != '0) begin
      if (ack_q.size() == 0) chk("unexpected_ack", 32'(core_rdy_ack), 32'h0);
      else chk("core_rdy_ack", 32'(core_rdy_ack), 32'(ack_q.pop_front()));
    end
    if (core_wr_en != '0) begin
      if (wr_q.size() == 0) chk("unexpected_wr", 32'(core_wr_en), 32'h0);
      else chk("core_wr_en", 32'(core_wr_en), 32'(wr_q.pop_front()));
    end
    if (core_done != '0) begin
      if (done_q.size() == 0) chk("unexpected_done", 32'(core_done), 32'h0);
      else chk("core_done", 32'(core_done), 32'(done_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step after entering OFFER; acks, writes nwr times, then done
  task automatic accept(input int g, input int nwr);
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    sn_rdy_ack = 1'b1;
    ack_q.push_back(oh);
    @(negedge clk);
    chk("offer_sn_rdy", 32'(sn_rdy), 32'd1);
    chk("offer_grant", 32'(grant_idx), 32'(g));
    chk("offer_busy", 32'(busy), 32'd0);
    step();
    sn_rdy_ack = 1'b0;
    for (int k = 0; k < nwr; k++) begin
      sn_wr_en = 1'b1;
      wr_q.push_back(oh);
      @(negedge clk);
      chk("busy_during_write", 32'(busy), 32'd1);
      step();
    end
    sn_wr_en = 1'b0;
    sn_done  = 1'b1;
    done_q.push_back(oh);
    step();
    sn_done = 1'b0;
  endtask

  task automatic run_packet(input int g);
    step();
    accept(g, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    core_rdy   = 4'b1111;
    sn_rdy_ack = 1'b0;
    sn_wr_en   = 1'b0;
    sn_done    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_sn_rdy", 32'(sn_rdy), 32'd0);
    chk("rst_stray", 32'(stray_done), 32'd0);
    chk("rst_wr", 32'(core_wr_en), 32'd0);
    step();
    rst_n = 1'b1;

    // First grant then rotation 0,1,2,3,0
    run_packet(0);
    run_packet(1);
    run_packet(2);
    run_packet(3);
    run_packet(0);

    // Skip and wrap with last=0
    core_rdy = 4'b1001;
    run_packet(3);
    run_packet(0);

    // Withdrawal in OFFER; stray ack while sn_rdy low is ignored
    core_rdy = 4'b0100;
    step();
    @(negedge clk);
    chk("wd_offer_rdy", 32'(sn_rdy), 32'd1);
    chk("wd_offer_grant", 32'(grant_idx), 32'd2);
    chk("wd_stray_pre", 32'(stray_done), 32'd0);
    step();
    core_rdy   = 4'b1000;
    sn_rdy_ack = 1'b1;
    @(negedge clk);
    chk("wd_sn_rdy_drop", 32'(sn_rdy), 32'd0);
    chk("wd_ack_none", 32'(core_rdy_ack), 32'd0);
    step();
    sn_rdy_ack = 1'b0;
    @(negedge clk);
    chk("wd_idle_busy", 32'(busy), 32'd0);
    chk("wd_idle_sn_rdy", 32'(sn_rdy), 32'd0);
    run_packet(3);

    // Stray done and ignored writes in IDLE
    core_rdy = 4'b0000;
    sn_done  = 1'b1;
    sn_wr_en = 1'b1;
    @(negedge clk);
    chk("stray_wr_blocked", 32'(core_wr_en), 32'd0);
    chk("stray_done_blocked", 32'(core_done), 32'd0);
    step();
    sn_done  = 1'b0;
    sn_wr_en = 1'b0;
    @(negedge clk);
    chk("stray_set", 32'(stray_done), 32'd1);
    repeat (3) step();
    @(negedge clk);
    chk("stray_sticky", 32'(stray_done), 32'd1);
    chk("stray_idle", 32'(busy), 32'd0);

    // Reset mid-packet on core 1 (last=3)
    step();
    core_rdy = 4'b0010;
    step();
    sn_rdy_ack = 1'b1;
    ack_q.push_back(4'b0010);
    @(negedge clk);
    chk("mid_grant", 32'(grant_idx), 32'd1);
    step();
    sn_rdy_ack = 1'b0;
    sn_wr_en   = 1'b1;
    wr_q.push_back(4'b0010);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr", 32'(core_wr_en), 32'd0);
    chk("mid_rst_grant", 32'(grant_idx), 32'd0);
    chk("mid_rst_done", 32'(core_done), 32'd0);
    chk("mid_rst_stray", 32'(stray_done), 32'd0);
    sn_wr_en = 1'b0;
    core_rdy = 4'b1111;
    step();
    rst_n = 1'b1;
    run_packet(0);

    repeat (2) step();
    chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sn_arbiter.md
# sn_arbiter

Round-robin arbiter that shares the single snooper write port among the N parallel packetfilter cores. It picks one idle core whose packet memory is free and offers it to the snooper. It then steers that snooper's write strobe and done pulse to the chosen core only, and returns to arbitration when the packet is finished. It sits between the snooper and the core array. Address and data go to every core; only the enables are steered.

## Interface

Parameters:
- N, 4, number of cores (2..16)
- SEL_WIDTH, 2, width of grant index; must equal CLOG2(N)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- core_rdy  in  N  per-core ready-for-snoop level (packet memory free)
- core_rdy_ack  out  N  per-core one-cycle acknowledge; at most one bit set
- core_wr_en  out  N  steered snooper write enable
- core_done  out  N  steered snooper done pulse
- sn_rdy  out  1  "a core is offered" to snooper
- sn_rdy_ack  in  1  snooper accepts the offer (one-cycle pulse)
- sn_wr_en  in  1  snooper write enable
- sn_done  in  1  snooper end-of-packet pulse
- grant_idx  out  SEL_WIDTH  index of the currently selected core
- busy  out  1  a packet is being written to the selected core
- stray_done  out  1  sticky: sn_done seen while not BUSY; cleared only by reset

## Operation

- State machine: IDLE, OFFER, BUSY.
- IDLE:
  - If any core_rdy bit is set, select the first set bit searching upward from last+1 (mod N), wrapping around.
  - Register the selection into grant_idx and go to OFFER.
  - If no bit is set, stay in IDLE.
- OFFER:
  - sn_rdy = core_rdy[grant_idx] (combinational).
  - If sn_rdy_ack and sn_rdy are both high: core_rdy_ack[grant_idx] = 1 for that cycle; last <= grant_idx; go to BUSY.
  - If core_rdy[grant_idx] is low (withdrawn): go to IDLE with no ack. last is not updated, so the search restarts from the same point.
  - An sn_rdy_ack arriving while sn_rdy is low is ignored.
- BUSY:
  - core_wr_en = sn_wr_en on bit grant_idx, zero elsewhere.
  - core_done = sn_done on bit grant_idx, zero elsewhere.
  - On sn_done, go to IDLE.
  - Changes on core_rdy are ignored in BUSY.
- Outside BUSY:
  - core_wr_en and core_done are all zero.
  - sn_done sets stray_done.
  - sn_wr_en is dropped.
- busy = (state == BUSY).
- Reset:
  - All outputs go to 0 immediately: state IDLE, grant_idx 0, stray_done 0.
  - last resets to N-1, so the first grant goes to the lowest ready index starting from core 0.
  - A reset during BUSY abandons the packet. No core_done is issued.

## Timing

- IDLE to OFFER takes 1 cycle. The earliest sn_rdy is 1 cycle after core_rdy rises.
- Ack path is combinational, 0 cycles: sn_rdy_ack to core_rdy_ack in the same cycle.
- core_wr_en and core_done are combinational from sn_wr_en and sn_done (0 latency). The grant is registered, so the steering select is stable for the whole packet.
- sn_done in BUSY: core_done is issued that cycle. The state is IDLE on the next edge. The earliest next sn_rdy is 2 cycles after the sn_done cycle.
- sn_done and sn_wr_en may be high in the same cycle. Both are forwarded.
- Minimum packet:
  - The ack cycle itself is still OFFER, so sn_wr_en in the ack cycle is not forwarded.
  - The snooper must start writing no earlier than the cycle after the ack.
- Fairness: a continuously ready core waits at most N-1 grants.
- Outputs are glitch-free with respect to state. All decode comes from registered state and grant_idx, ANDed with inputs.

## Test plan

- Reset and first grant:
  - Stimulus: release rst_n with core_rdy=4'b1111.
  - Required: cycle 1 sn_rdy=1, grant_idx=0. Ack gives core_rdy_ack=4'b0001 in the same cycle, then busy=1.
- Round-robin rotation:
  - Stimulus: keep all cores ready; run 5 packets of 3 writes plus done.
  - Required: grant order 0,1,2,3,0. core_wr_en pulses only on the granted bit, 3 per packet. core_done fires once per packet.
- Skip and wrap:
  - Stimulus: core_rdy=4'b1001 with last=0.
  - Required: next grant is 3, then 0. Cores 1 and 2 never see ack or write enables.
- Withdrawal in OFFER:
  - Stimulus: core 2 offered, core 2 drops core_rdy before the ack; core_rdy=4'b0100→4'b1000.
  - Required: sn_rdy falls the same cycle, no core_rdy_ack. IDLE, then grant_idx=3.
- Stray done and ignored writes:
  - Stimulus: pulse sn_done and sn_wr_en in IDLE.
  - Required: stray_done=1 and stays set. core_done=0, core_wr_en=0.
- Reset mid-packet:
  - Stimulus: assert rst_n low during BUSY on core 1.
  - Required: busy, core_wr_en and grant_idx go to 0 asynchronously, with no core_done. After release, the first grant goes to core 0.
